iter_div: RTL
=============

Name: iter_div

Overview:
- Multi-cycle radix-2 restoring integer divider for the execute stage. It is the inverse operation to the single-cycle Wallace/Booth multiplier.
- Serves DIV.W/DIV.WU/MOD.W/MOD.WU, producing quotient and remainder together.
- Valid/ready handshake on both sides. A pipeline flush cancels an in-flight operation.
- One quotient bit is produced per cycle.

Parameters:
WIDTH, 32, operand/result width in bits. Only 32 is required to be verified.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  cancel in-flight/pending operation (exception/branch flush)
in_valid  input  1  operands present
in_ready  output  1  divider can accept operands
sign  input  1  1 = signed (two's complement), 0 = unsigned
x  input  WIDTH  dividend
y  input  WIDTH  divisor
out_valid  output  1  q/r/div_zero valid
out_ready  input  1  consumer takes result
q  output  WIDTH  quotient
r  output  WIDTH  remainder
div_zero  output  1  divisor was zero for this result

Behaviour:
- Reset (rst=1 at edge):
  - State = IDLE.
  - out_valid=0, q=0, r=0, div_zero=0, internal counter=0.
  - rst overrides every other input, including mid-operation.
- State machine has three states:
  - IDLE
    - in_ready=1.
    - Accept at an edge when in_valid && !flush.
    - At accept, latch sign, x sign bit, y sign bit, |x| and |y|. When sign=1 these are two's-complement magnitudes; when sign=0 they are the raw values.
    - Counter is cleared at accept.
    - If y==0: go to DONE with q=all-ones, r=x (unmodified), div_zero=1.
    - Otherwise go to BUSY.
  - BUSY
    - in_ready=0.
    - Each cycle: shift {partial remainder, dividend} left by 1; trial subtract |y| from the WIDTH+1-bit partial remainder.
    - If the difference is non-negative, keep the difference and set quotient bit = 1; otherwise restore and set quotient bit = 0.
    - Counter increments each cycle.
    - At the edge completing the WIDTH-th iteration, go to DONE and load q and r with sign fix-up:
      - q is negated iff sign && (x sign != y sign).
      - r is negated iff sign && (x sign = 1).
    - div_zero=0.
  - DONE
    - out_valid=1, in_ready=0.
    - q, r and div_zero stay stable until the handshake completes.
    - When out_ready=1 at an edge, go to IDLE; out_valid drops the next cycle.
    - No new operation is accepted in the same cycle as the result hand-off.
- Latency:
  - Non-zero divisor: out_valid rises WIDTH cycles after the accept edge (32 for WIDTH=32).
  - Zero divisor: out_valid rises 1 cycle after the accept edge.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - x == q*y + r holds modulo 2^WIDTH.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0 (natural result of magnitude/truncation). No flag.
- Flush:
  - flush=1 in BUSY or DONE → IDLE at that edge; out_valid=0 next cycle; the result is discarded.
  - flush=1 in IDLE blocks acceptance even when in_valid=1.
  - flush and out_ready both high in DONE: the result is dropped. The consumer must ignore it, since flush has priority.
- Output registers q and r hold their last values in IDLE/BUSY. They have no meaning unless out_valid=1.

Test Plan:
- Unsigned basic: sign=0, x=100, y=7 → out_valid exactly 32 cycles after accept; q=14, r=2, div_zero=0.
- Signed versus unsigned, same bits:
  - sign=1, x=0xFFFFFFF9, y=2 → q=0xFFFFFFFD, r=0xFFFFFFFF.
  - sign=0, same operands → q=0x7FFFFFFC, r=1.
- Divide by zero: x=5, y=0, sign=1 → out_valid 1 cycle after accept; q=0xFFFFFFFF, r=5, div_zero=1.
- Signed overflow and boundaries:
  - 0x80000000 / 0xFFFFFFFF (signed) → q=0x80000000, r=0.
  - 0xFFFFFFFF / 1 (unsigned) → q=0xFFFFFFFF, r=0.
  - 3 / 10 → q=0, r=3.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid → q/r stable and in_ready=0 throughout.
  - Raise out_ready; a second op (50/5 → q=10, r=0) is accepted on the following IDLE cycle.
- Flush and reset mid-op:
  - flush at BUSY iteration 10 → no out_valid; in_ready=1 next cycle.
  - rst at iteration 20 → all outputs 0, state IDLE.
  - A subsequent op (9/4 → q=2, r=1) completes correctly in 32 cycles.

Source files
------------

// File: rtl/iter_div_if.sv
// Operand/result handshake bundle for the iterative divider.
interface iter_div_if #(
  parameter int unsigned Width = 32
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic [Width-1:0] x;
  logic [Width-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] q;
  logic [Width-1:0] r;
  logic             div_zero;

  modport master (
    output flush, in_valid, sign, x, y, out_ready,
    input  in_ready, out_valid, q, r, div_zero
  );

  modport slave (
    input  flush, in_valid, sign, x, y, out_ready,
    output in_ready, out_valid, q, r, div_zero
  );
endinterface

// File: rtl/iter_div.sv
// Radix-2 restoring divider: one quotient bit per cycle, signed handled by
// dividing magnitudes and fixing up signs on the final iteration.
module iter_div #(
  parameter int unsigned Width = 32
) (
  input logic      clk,
  input logic      rst,
  iter_div_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] rem_q, rem_d;   // partial remainder
  logic [Width-1:0] dvd_q, dvd_d;   // dividend bits shifting out, quotient bits shifting in
  logic [Width-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic             sign_q, sign_d;
  logic             xs_q, xs_d;
  logic             ys_q, ys_d;
  logic [Width-1:0] q_q, q_d;
  logic [Width-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic [Width:0]   shifted;
  logic [Width:0]   diff;
  logic             qbit;
  logic [Width-1:0] quot_nxt;
  logic [Width-1:0] rem_nxt;
  logic [Width-1:0] x_abs;
  logic [Width-1:0] y_abs;

  assign accept = bus_io.in_valid && !bus_io.flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush beats completion and hand-off.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (bus_io.y == '0) ? StDone : StBusy;
      end
      StBusy: begin
        if (bus_io.flush)          state_d = StIdle;
        else if (cnt_q == LastCnt) state_d = StDone;
      end
      StDone: begin
        if (bus_io.flush || bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and the result registers.
  always_comb begin
    bus_io.in_ready  = (state_q == StIdle);
    bus_io.out_valid = (state_q == StDone);
    bus_io.q         = q_q;
    bus_io.r         = r_q;
    bus_io.div_zero  = dz_q;
  end

  // Datapath next-state: operand capture, shift/subtract step, sign fix-up.
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    sign_d = sign_q;
    xs_d   = xs_q;
    ys_d   = ys_q;
    q_d    = q_q;
    r_d    = r_q;
    dz_d   = dz_q;

    // Shifted remainder needs Width+1 bits: it may exceed the divisor range.
    shifted  = {rem_q, dvd_q[Width-1]};
    diff     = shifted - {1'b0, dvs_q};
    qbit     = ~diff[Width];
    quot_nxt = {dvd_q[Width-2:0], qbit};
    rem_nxt  = qbit ? diff[Width-1:0] : shifted[Width-1:0];

    x_abs = (bus_io.sign && bus_io.x[Width-1]) ? (~bus_io.x + 1'b1) : bus_io.x;
    y_abs = (bus_io.sign && bus_io.y[Width-1]) ? (~bus_io.y + 1'b1) : bus_io.y;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sign_d = bus_io.sign;
          xs_d   = bus_io.x[Width-1];
          ys_d   = bus_io.y[Width-1];
          dvd_d  = x_abs;
          dvs_d  = y_abs;
          rem_d  = '0;
          cnt_d  = '0;
          if (bus_io.y == '0) begin
            q_d  = '1;
            r_d  = bus_io.x;
            dz_d = 1'b1;
          end
        end
      end
      StBusy: begin
        if (!bus_io.flush) begin
          rem_d = rem_nxt;
          dvd_d = quot_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            q_d  = (sign_q && (xs_q != ys_q)) ? (~quot_nxt + 1'b1) : quot_nxt;
            r_d  = (sign_q && xs_q) ? (~rem_nxt + 1'b1) : rem_nxt;
            dz_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      sign_q <= 1'b0;
      xs_q   <= 1'b0;
      ys_q   <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      sign_q <= sign_d;
      xs_q   <= xs_d;
      ys_q   <= ys_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dz_q   <= dz_d;
    end
  end

endmodule
